// File: rtl/netlist_bist_driver.sv
// LFSR stimulus / MISR response BIST driver for one combinational netlist.
// Optional X-masking of netlist outputs when NETLIST_BIST_XMASK_EN is defined.
module netlist_bist_driver #(
   parameter int unsigned IN_W  = 14,
   parameter int unsigned OUT_W = 8,
   parameter int unsigned N_PAT = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [15:0]      seed,
   input  logic [15:0]      golden,
   output logic [IN_W-1:0]  pi_vec,
   input  logic [OUT_W-1:0] po_vec,
`ifdef NETLIST_BIST_XMASK_EN
   input  logic [OUT_W-1:0] po_mask,
`endif
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      signature
);

   localparam int unsigned CNT_W = $clog2(N_PAT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEED = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state, state_nx;
   logic [15:0]      lfsr, lfsr_nx;
   logic [15:0]      misr, misr_nx;
   logic [CNT_W-1:0] pat_cnt, pat_cnt_nx;
   logic [IN_W-1:0]  pi_nx;
   logic             pass_nx;

   logic [15:0]      seed_eff;
   logic [15:0]      lfsr_step;
   logic [15:0]      misr_step;
   logic [OUT_W-1:0] po_eff;

`ifdef NETLIST_BIST_XMASK_EN
   assign po_eff = po_vec & ~po_mask;
`else
   assign po_eff = po_vec;
`endif

   // An all-zero seed would lock the LFSR, so substitute 1.
   assign seed_eff  = (seed == 16'h0000) ? 16'h0001 : seed;
   assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign misr_step = {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]} ^ 16'(po_eff);

   always_comb begin
      state_nx   = state;
      lfsr_nx    = lfsr;
      misr_nx    = misr;
      pat_cnt_nx = pat_cnt;
      pi_nx      = pi_vec;
      pass_nx    = pass;
      if (abort) begin
         state_nx = S_IDLE;
         pass_nx  = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) state_nx = S_SEED;
            end
            S_SEED: begin
               lfsr_nx    = seed_eff;
               pi_nx      = seed_eff[IN_W-1:0];
               misr_nx    = 16'h0000;
               pat_cnt_nx = '0;
               state_nx   = S_RUN;
            end
            S_RUN: begin
               misr_nx    = misr_step;
               pat_cnt_nx = pat_cnt + 1'b1;
               if (pat_cnt == CNT_W'(N_PAT - 1)) begin
                  // Last pattern absorbed: pi_vec and lfsr freeze here.
                  state_nx = S_DONE;
                  pass_nx  = (misr_step == golden);
               end else begin
                  lfsr_nx = lfsr_step;
                  pi_nx   = lfsr_step[IN_W-1:0];
               end
            end
            S_DONE: begin
               if (start) begin
                  state_nx = S_SEED;
                  pass_nx  = 1'b0;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         lfsr    <= 16'h0001;
         misr    <= 16'h0000;
         pat_cnt <= '0;
         pi_vec  <= '0;
         pass    <= 1'b0;
      end else begin
         state   <= state_nx;
         lfsr    <= lfsr_nx;
         misr    <= misr_nx;
         pat_cnt <= pat_cnt_nx;
         pi_vec  <= pi_nx;
         pass    <= pass_nx;
      end
   end

   assign busy      = (state == S_SEED) || (state == S_RUN);
   assign done      = (state == S_DONE);
   assign signature = misr;

endmodule

// File: tb/tb_netlist_bist_driver.sv
// Directed bench for netlist_bist_driver: an N_PAT=4 instance with zero response
// and an N_PAT=16 instance in loopback (po_vec = pi_vec[7:0]).
module tb_netlist_bist_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] seed;
   logic [15:0] golden4;
   logic [15:0] golden16;
   logic [7:0]  po_mask;
   logic        use_rand;
   logic [7:0]  rand_po;

   logic [13:0] pi4, pi16;
   logic [7:0]  po4, po16;
   logic        busy4, done4, pass4;
   logic        busy16, done16, pass16;
   logic [15:0] sig4, sig16;

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_sig;

   always #5 clk = ~clk;

   assign po4  = 8'h00;
   assign po16 = use_rand ? rand_po : pi16[7:0];

   netlist_bist_driver #(.IN_W(14), .OUT_W(8), .N_PAT(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .seed      (seed),
      .golden    (golden4),
      .pi_vec    (pi4),
      .po_vec    (po4),
`ifdef NETLIST_BIST_XMASK_EN
      .po_mask   (po_mask),
`endif
      .busy      (busy4),
      .done      (done4),
      .pass      (pass4),
      .signature (sig4)
   );

   netlist_bist_driver #(.IN_W(14), .OUT_W(8), .N_PAT(16)) u_dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .seed      (seed),
      .golden    (golden16),
      .pi_vec    (pi16),
      .po_vec    (po16),
`ifdef NETLIST_BIST_XMASK_EN
      .po_mask   (po_mask),
`endif
      .busy      (busy16),
      .done      (done16),
      .pass      (pass16),
      .signature (sig16)
   );

   // Reference: loopback response po = pi[7:0] = lfsr[7:0].
   function automatic logic [15:0] model_sig(input logic [15:0] s, input int n);
      logic [15:0] l, m;
      l = (s == 16'h0000) ? 16'h0001 : s;
      m = 16'h0000;
      for (int i = 0; i < n; i++) begin
         m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {8'h00, l[7:0]};
         l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      seed     = 16'h0000;
      golden4  = 16'h0000;
      golden16 = 16'h0000;
      po_mask  = 8'h00;
      use_rand = 1'b0;
      rand_po  = 8'h00;
      tick();
      tick();
      chk("rst_pi",   32'(pi16),   32'h0);
      chk("rst_busy", 32'(busy16), 32'h0);
      chk("rst_done", 32'(done16), 32'h0);
      chk("rst_pass", 32'(pass16), 32'h0);
      chk("rst_sig",  32'(sig16),  32'h0);
      rst_n = 1'b1;
      tick();

      // Zero seed, zero response, N_PAT=4.
      seed  = 16'h0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("z_busy", 32'(busy4), 32'h1);
      tick(); chk("z_pi0", 32'(pi4), 32'h0001);
      tick(); chk("z_pi1", 32'(pi4), 32'h0002);
      tick(); chk("z_pi2", 32'(pi4), 32'h0004);
      tick(); chk("z_pi3", 32'(pi4), 32'h0008);
      chk("z_notdone", 32'(done4), 32'h0);
      tick();
      chk("z_done", 32'(done4), 32'h1);
      chk("z_pihold", 32'(pi4), 32'h0008);
      chk("z_sig", 32'(sig4), 32'h0);
      chk("z_pass", 32'(pass4), 32'h1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("z_abort_done", 32'(done4), 32'h0);

      // Loopback, seed ACE1, N_PAT=16.
      seed     = 16'hACE1;
      exp_sig  = model_sig(16'hACE1, 16);
      golden16 = exp_sig;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (16) tick();
      chk("lb_edge16_done", 32'(done16), 32'h0);
      tick();
      chk("lb_edge17_done", 32'(done16), 32'h1);
      chk("lb_sig", 32'(sig16), 32'(exp_sig));
      chk("lb_pass", 32'(pass16), 32'h1);
      golden16 = exp_sig ^ 16'h0001;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("lb_rerun_pass_clr", 32'(pass16), 32'h0);
      chk("lb_rerun_busy", 32'(busy16), 32'h1);
      repeat (17) tick();
      chk("lb_bad_done", 32'(done16), 32'h1);
      chk("lb_bad_pass", 32'(pass16), 32'h0);
      chk("lb_bad_sig", 32'(sig16), 32'(exp_sig));

      // Abort during RUN cycle 5: four patterns absorbed.
      golden16 = exp_sig;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_busy", 32'(busy16), 32'h0);
      chk("ab_done", 32'(done16), 32'h0);
      chk("ab_sig", 32'(sig16), 32'(model_sig(16'hACE1, 4)));
      tick();
      chk("ab_idle", 32'(busy16), 32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (17) tick();
      chk("ab_rerun_sig", 32'(sig16), 32'(exp_sig));
      chk("ab_rerun_pass", 32'(pass16), 32'h1);

      // start during RUN ignored; start+abort goes to IDLE.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      chk("st_run_done", 32'(done16), 32'h0);
      chk("st_run_busy", 32'(busy16), 32'h1);
      tick();
      chk("st_done", 32'(done16), 32'h1);
      chk("st_sig", 32'(sig16), 32'(exp_sig));
      start = 1'b1;
      abort = 1'b1;
      tick();
      chk("sa_busy", 32'(busy16), 32'h0);
      chk("sa_done", 32'(done16), 32'h0);
      chk("sa_pass", 32'(pass16), 32'h0);
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_idle_busy", 32'(busy16), 32'h0);
      tick();
      chk("sa_noseed", 32'(busy16), 32'h0);

      // Asynchronous reset mid-RUN.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("rr_busy_pre", 32'(busy16), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rr_pi",   32'(pi16),   32'h0);
      chk("rr_busy", 32'(busy16), 32'h0);
      chk("rr_done", 32'(done16), 32'h0);
      chk("rr_pass", 32'(pass16), 32'h0);
      chk("rr_sig",  32'(sig16),  32'h0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("rr_stay_idle", 32'(busy16), 32'h0);
      chk("rr_stay_done", 32'(done16), 32'h0);

`ifdef NETLIST_BIST_XMASK_EN
      // Fully masked random response: signature equals the zero-response one.
      po_mask  = 8'hFF;
      use_rand = 1'b1;
      start    = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 17; i++) begin
         rand_po = 8'($urandom);
         tick();
      end
      chk("xm_done", 32'(done16), 32'h1);
      chk("xm_sig", 32'(sig16), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
